// File: rtl/regfile_dump.sv
// +----------------------------------------------------------------------------+
// | regfile_dump: walks the register file read port and streams (idx, value)  |
// | beats over valid/ready with a running XOR checksum.  Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_dump #(
  parameter int NREGS     = 32,
  parameter int IW        = $clog2(NREGS),
  parameter int SKIP_ZERO = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          hold_wr,
  output logic          done,
  output logic [IW-1:0] rsel,
  input  logic [31:0]   rdat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [31:0]   out_data,
  output logic [31:0]   checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IW-1:0] c_FIRST = (SKIP_ZERO != 0) ? IW'(1) : '0;
  localparam logic [IW-1:0] c_LAST  = IW'(NREGS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_out_idx;
  logic [31:0]   r_out_data;
  logic [31:0]   r_checksum;
  logic          w_fire;

  assign w_fire = (r_state == S_SEND) && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        // abort wins the transition even when the beat is accepted
        if (abort)       w_next = S_IDLE;
        else if (w_fire) w_next = (r_idx == c_LAST) ? S_DONE : S_READ;
      end
      S_DONE: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx      <= '0;
      r_out_idx  <= '0;
      r_out_data <= '0;
      r_checksum <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_idx      <= c_FIRST;
        r_checksum <= '0;
      end
      if (r_state == S_READ) begin
        r_out_data <= rdat;
        r_out_idx  <= r_idx;
      end
      if (w_fire) begin
        r_checksum <= r_checksum ^ r_out_data;
        if (!abort && (r_idx != c_LAST)) r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy      = (r_state == S_READ) || (r_state == S_SEND);
  assign hold_wr   = busy;
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_SEND);
  assign rsel      = busy ? r_idx : '0;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign checksum  = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_dump: randomized dumps of two engines (SKIP_ZERO 0 and 1)       |
// | against a queue-based model of the expected beat stream. Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_dump;

  localparam int NR = 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_s[2], abort_s[2], busy_s[2], hold_s[2], done_s[2];
  logic        valid_s[2], ready_s[2];
  logic [4:0]  rsel_s[2], idx_s[2];
  logic [31:0] rdat_s[2], data_s[2], ck_s[2];
  logic [31:0] regs[NR];

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign rdat_s[0] = regs[rsel_s[0]];
  assign rdat_s[1] = regs[rsel_s[1]];

  regfile_dump #(.NREGS(NR), .SKIP_ZERO(0)) dut0 (
    .CLK(CLK), .RST(RST), .start(start_s[0]), .abort(abort_s[0]),
    .busy(busy_s[0]), .hold_wr(hold_s[0]), .done(done_s[0]),
    .rsel(rsel_s[0]), .rdat(rdat_s[0]), .out_valid(valid_s[0]),
    .out_ready(ready_s[0]), .out_idx(idx_s[0]), .out_data(data_s[0]),
    .checksum(ck_s[0])
  );

  regfile_dump #(.NREGS(NR), .SKIP_ZERO(1)) dut1 (
    .CLK(CLK), .RST(RST), .start(start_s[1]), .abort(abort_s[1]),
    .busy(busy_s[1]), .hold_wr(hold_s[1]), .done(done_s[1]),
    .rsel(rsel_s[1]), .rdat(rdat_s[1]), .out_valid(valid_s[1]),
    .out_ready(ready_s[1]), .out_idx(idx_s[1]), .out_data(data_s[1]),
    .checksum(ck_s[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input int d);
    check_val("rst_busy",  busy_s[d],  0);
    check_val("rst_hold",  hold_s[d],  0);
    check_val("rst_done",  done_s[d],  0);
    check_val("rst_valid", valid_s[d], 0);
    check_val("rst_rsel",  rsel_s[d],  0);
    check_val("rst_idx",   idx_s[d],   0);
    check_val("rst_data",  data_s[d],  0);
    check_val("rst_ck",    ck_s[d],    0);
  endtask

  // One dump on engine d; beat numbers are positions in the emitted stream.
  task automatic dump(input int d, input int ready_pct, input int stall_beat,
                      input int abort_beat, input int rst_beat, input bit repulse);
    int          first, nb, beat, n, stall;
    int          exp_idx[$];
    logic [31:0] exp_dat[$];
    logic [31:0] eck;
    bit          fin, hs, do_abort, do_rst, saw_done;
    first = d;
    nb    = NR - first;
    for (int i = first; i < NR; i++) begin
      exp_idx.push_back(i);
      exp_dat.push_back(regs[i]);
    end
    eck = '0; beat = 0; n = 0; stall = 0; fin = 1'b0;

    start_s[d] = 1'b1; abort_s[d] = 1'b0; ready_s[d] = 1'b1;
    tick();
    n++;
    start_s[d] = 1'b0;
    check_val("start_busy", busy_s[d], 1);
    check_val("start_hold", hold_s[d], 1);
    check_val("start_rsel", rsel_s[d], first);
    check_val("start_ck",   ck_s[d],   0);

    while (!fin) begin
      if (n > 4000) begin
        check_val("cycle_budget", n, 4000);
        break;
      end
      if (stall_beat == beat && stall < 10 && valid_s[d]) begin
        ready_s[d] = 1'b0;
        stall++;
      end else begin
        ready_s[d] = ($urandom_range(99) < ready_pct);
      end
      start_s[d] = repulse && busy_s[d] && ($urandom_range(3) == 0);
      do_abort   = (beat == abort_beat) && valid_s[d] && ready_s[d];
      do_rst     = (beat == rst_beat) && valid_s[d];
      abort_s[d] = do_abort;
      RST        = do_rst;

      if (valid_s[d]) begin
        if (beat >= nb) begin
          check_val("beat_overrun", beat, nb - 1);
          fin = 1'b1;
        end else begin
          check_val("beat_idx",  idx_s[d],  exp_idx[beat]);
          check_val("beat_data", data_s[d], exp_dat[beat]);
        end
      end
      saw_done = done_s[d];
      if (saw_done) begin
        if (ready_pct == 100 && stall_beat < 0)
          check_val("done_latency", n + 1, 2 + 2 * nb);
        check_val("done_beats", beat, nb);
        check_val("done_ck",    ck_s[d], eck);
      end
      hs = valid_s[d] && ready_s[d] && !do_rst;
      if (hs && beat < nb) begin
        eck = eck ^ exp_dat[beat];
        beat++;
      end

      tick();
      n++;

      if (do_rst) begin
        RST = 1'b0;
        check_reset(d);
        fin = 1'b1;
      end else if (do_abort) begin
        abort_s[d] = 1'b0;
        check_val("abort_valid", valid_s[d], 0);
        check_val("abort_busy",  busy_s[d],  0);
        check_val("abort_done",  done_s[d],  0);
        check_val("abort_ck",    ck_s[d],    eck);
        tick();
        check_val("abort_nodone", done_s[d], 0);
        fin = 1'b1;
      end else if (saw_done) begin
        check_val("post_done",  done_s[d],  0);
        check_val("post_busy",  busy_s[d],  0);
        check_val("post_hold",  hold_s[d],  0);
        check_val("post_valid", valid_s[d], 0);
        check_val("post_ck",    ck_s[d],    eck);
        fin = 1'b1;
      end
    end
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
    ready_s[d] = 1'b1;
  endtask

  initial begin
    RST = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; abort_s[d] = 1'b0; ready_s[d] = 1'b1;
    end
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
    tick();
    tick();
    check_reset(0);
    check_reset(1);
    RST = 1'b0;
    tick();

    dump(0, 100, -1, -1, -1, 1'b0);
    dump(1, 100, -1, -1, -1, 1'b0);
    dump(0, 60, 7, -1, -1, 1'b1);
    dump(0, 100, -1, -1, -1, 1'b1);
    dump(0, 70, -1, 5, -1, 1'b0);

    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    dump(0, 50, 3, -1, -1, 1'b1);
    dump(0, 80, -1, -1, 12, 1'b0);
    dump(1, 50, 20, -1, -1, 1'b1);
    dump(1, 60, -1, 9, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_dump.md
# regfile_dump

Sequential reader for the register file's read port. On `start`, walks register indices 0..NREGS-1 through `rsel`, captures each `rdat`, and streams (index, value) beats to a downstream consumer over a valid/ready handshake, while keeping a running XOR checksum. Used at halt for end-of-program register dumps and by the debug path; it owns one read port for the duration of a dump and asks the pipeline to hold writes.

## Interface
- NREGS, 32: number of registers walked; power of two, ≥ 2.
- IW, $clog2(NREGS): index width, derived; 5 at default.
- SKIP_ZERO, 0: if 1, the walk starts at index 1; register 0 is hardwired to zero and is not emitted.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  cancel an in-progress dump.
- busy  out  1  high in READ and SEND.
- hold_wr  out  1  equals busy; pipeline must suppress register-file writes while high.
- done  out  1  one-cycle pulse after the last beat is accepted.
- rsel  out  IW  read select into the register file read port.
- rdat  in  32  combinational read data for `rsel`.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_idx  out  IW  register index of the current beat.
- out_data  out  32  register value of the current beat.
- checksum  out  32  XOR of all `out_data` accepted in the current or last dump.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `rsel` = 0. On `start`, set idx to first (0, or 1 if SKIP_ZERO), clear checksum, go to READ.
- READ: `rsel` = idx. Register `out_data` <= `rdat` and `out_idx` <= idx, go to SEND.
- SEND: `out_valid` = 1; `out_data` and `out_idx` hold stable until accepted. On `out_valid && out_ready`:
  - checksum <= checksum ^ out_data.
  - If idx == NREGS-1, go to DONE; otherwise idx <= idx+1 and go to READ.
- DONE: `done` = 1 for exactly this cycle, then go to IDLE. `checksum` holds its value until the next `start`.
- abort in READ or SEND: go to IDLE next cycle. No `done` pulse; `checksum` keeps its partial value.
  - abort and a handshake in the same cycle: the beat counts as delivered and is folded into `checksum`, but abort still wins the state transition.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `start` wins.
- idx is IW bits and never increments past NREGS-1, so there is no wrap-around.
- `out_valid` never drops without a handshake, except on abort or RST.

## Timing
- Reset (RST high at an edge): state IDLE, idx 0.
  - Outputs after reset: `busy`, `hold_wr`, `done`, `out_valid` = 0; `rsel`, `out_idx` = 0; `out_data`, `checksum` = 0.
  - RST mid-dump overrides everything; there is no done pulse.
- Latency: `start` sampled at edge 0 → READ during cycle 1 → `out_valid` high from edge 2.
- Each beat takes 2 cycles with `out_ready` tied high.
  - Full dump from `start` to `done`: 1 + 2·N + 1 cycles, where N = NREGS − SKIP_ZERO. This is 66 cycles at the defaults.
- `hold_wr` rises at the edge where `start` is accepted and falls at the edge entering DONE. The register file therefore cannot be written between the READ sample and the end of the dump.
- The engine samples `rdat` in the same cycle `rsel` is driven, relying on the register file's combinational read.

## Test plan
- Preload register i with 0x1000_0000+i, SKIP_ZERO=0, `out_ready`=1, pulse `start`:
  - 32 beats with idx 0..31, data equal to the preload.
  - `done` pulses exactly once, 66 cycles after `start`.
  - `checksum` = XOR of the preload values; `busy` low afterwards.
- Same preload, SKIP_ZERO=1: first beat has `out_idx`=1, 31 beats total, `done` 64 cycles after `start`.
- Random `out_ready` backpressure, including ready low for 10 cycles mid-beat: `out_data`/`out_idx` stay stable while valid and unaccepted; no beats are dropped or duplicated; `checksum` is unchanged versus the no-stall run.
- `abort` asserted on the same cycle as the handshake of beat 5:
  - Beat 5 counts as delivered; next cycle is IDLE with `out_valid`=0.
  - No `done`; `checksum` = XOR of beats 0..5.
- RST asserted during SEND of beat 12: next cycle all outputs are at reset values, with `checksum`=0.
- `start` re-pulsed during a dump is ignored, and the beat sequence is unaffected.
  - A fresh `start` the cycle after `done` produces a second full dump, with `checksum` cleared first.
